// File: rtl/stopwatch_pkg.sv
// Shared types and the active-high seven-segment lookup for the stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    // Segment order {g,f,e,d,c,b,a}, 1 = lit.
    localparam logic [6:0] SEG_LUT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD digit to a seven-segment pattern; codes above 9 blank the display.
import stopwatch_pkg::*;

module bcd_to_7seg #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_raw;

    always_comb begin
        seg_raw = 7'h00;
        if (bcd_i <= 4'd9) begin
            seg_raw = SEG_LUT[bcd_i];
        end
    end

    assign seg_o = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

endmodule

// File: rtl/stopwatch_bcd.sv
// mm:ss.t stopwatch driven by a synchronised 10 Hz tick, with 7-segment outputs.
// Optional lap-freeze display is built when STOPWATCH_LAP_EN is defined.
import stopwatch_pkg::*;

module stopwatch_bcd #(
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_TENS_MAX   = 5,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [19:0] digits,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        running,
    output logic        wrap
);

    localparam bcd_t       MIN_T_MAX = bcd_t'(MIN_TENS_MAX);
    localparam logic [6:0] SEG_ZERO  = SEG_ACTIVE_LOW ? ~SEG_LUT[0] : SEG_LUT[0];

    logic [SYNC_STAGES-1:0] tick_sync_q;
    logic                   tick_prev_q;
    logic                   tick_en;
    logic [2:0]             btn_q;
    logic [2:0]             btn_prev_q;
    logic [2:0]             btn_pulse;
    logic                   ss_pulse;
    logic                   lap_pulse;
    logic                   clear_lvl;
    state_e                 state_q, state_d;
    bcd_t                   min_t_q, min_u_q, sec_t_q, sec_u_q, tenth_q;
    logic                   wrap_q;
    logic                   count_inc;
    logic [19:0]            live_count;

    // Tick and buttons are plain data into this clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_sync_q <= '0;
            tick_prev_q <= 1'b0;
            btn_q       <= 3'b000;
            btn_prev_q  <= 3'b000;
        end else begin
            tick_sync_q <= {tick_sync_q[SYNC_STAGES-2:0], tick_in};
            tick_prev_q <= tick_sync_q[SYNC_STAGES-1];
            btn_q       <= {lap, clear, start_stop};
            btn_prev_q  <= btn_q;
        end
    end

    assign tick_en   = tick_sync_q[SYNC_STAGES-1] & ~tick_prev_q;
    assign btn_pulse = btn_q & ~btn_prev_q;
    assign ss_pulse  = btn_pulse[0];
    assign lap_pulse = btn_pulse[2];
    assign clear_lvl = btn_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!clear_lvl && ss_pulse) state_d = RUN;
            RUN:     if (clear_lvl) state_d = IDLE;
                     else if (ss_pulse) state_d = PAUSE;
            PAUSE:   if (clear_lvl) state_d = IDLE;
                     else if (ss_pulse) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Current state gates counting, so a tick coinciding with a pause still lands.
    assign count_inc = (state_q == RUN) && tick_en && !clear_lvl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {min_t_q, min_u_q, sec_t_q, sec_u_q, tenth_q} <= 20'h00000;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (clear_lvl) begin
                {min_t_q, min_u_q, sec_t_q, sec_u_q, tenth_q} <= 20'h00000;
            end else if (count_inc) begin
                if (tenth_q != 4'd9) begin
                    tenth_q <= tenth_q + 4'd1;
                end else begin
                    tenth_q <= 4'd0;
                    if (sec_u_q != 4'd9) begin
                        sec_u_q <= sec_u_q + 4'd1;
                    end else begin
                        sec_u_q <= 4'd0;
                        if (sec_t_q != 4'd5) begin
                            sec_t_q <= sec_t_q + 4'd1;
                        end else begin
                            sec_t_q <= 4'd0;
                            if (min_u_q != 4'd9) begin
                                min_u_q <= min_u_q + 4'd1;
                            end else begin
                                min_u_q <= 4'd0;
                                if (min_t_q != MIN_T_MAX) begin
                                    min_t_q <= min_t_q + 4'd1;
                                end else begin
                                    min_t_q <= 4'd0;
                                    wrap_q  <= 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    assign live_count = {min_t_q, min_u_q, sec_t_q, sec_u_q, tenth_q};
    assign running    = (state_q == RUN);
    assign wrap       = wrap_q;

`ifdef STOPWATCH_LAP_EN
    logic        freeze_q;
    logic [19:0] lap_digits_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freeze_q     <= 1'b0;
            lap_digits_q <= 20'h00000;
        end else if (freeze_q) begin
            if (lap_pulse || ss_pulse || clear_lvl) begin
                freeze_q <= 1'b0;
            end
        end else if (lap_pulse && (state_q == RUN) && !ss_pulse && !clear_lvl) begin
            freeze_q     <= 1'b1;
            lap_digits_q <= live_count;
        end
    end

    assign digits = freeze_q ? lap_digits_q : live_count;
`else
    logic lap_unused;
    assign lap_unused = lap_pulse;
    assign digits     = live_count;
`endif

    logic [6:0] hex_all [5];

    for (genvar gi = 0; gi < 5; gi++) begin : g_seg
        logic [6:0] seg_d;
        logic [6:0] hex_q;

        bcd_to_7seg #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_seg (
            .bcd_i(digits[gi*4 +: 4]),
            .seg_o(seg_d)
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hex_q <= SEG_ZERO;
            end else begin
                hex_q <= seg_d;
            end
        end

        assign hex_all[gi] = hex_q;
    end

    assign hex0 = hex_all[0];
    assign hex1 = hex_all[1];
    assign hex2 = hex_all[2];
    assign hex3 = hex_all[3];
    assign hex4 = hex_all[4];

endmodule
